// File: rtl/ternary_pkg.sv
// Shared definitions for the ternary perceptron datapath: crumb codes,
// loader state encoding and the default frame size.
package ternary_pkg;

  localparam int TW_N_WEIGHTS_DEFAULT = 4;

  // 2-bit ternary weight codes ("crumbs")
  localparam logic [1:0] TW_ZERO = 2'b00;
  localparam logic [1:0] TW_POS  = 2'b01;
  localparam logic [1:0] TW_RSVD = 2'b10;
  localparam logic [1:0] TW_NEG  = 2'b11;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } tw_state_e;

  function automatic logic tw_is_rsvd(input logic [1:0] c);
    return c == TW_RSVD;
  endfunction

endpackage

// File: rtl/ternary_crumb_check.sv
// Crumb sanitiser: the reserved code is turned into a zero weight so it can
// never reach the perceptron as a meaningful value, and is flagged.
module ternary_crumb_check
  import ternary_pkg::*;
(
  input  logic [1:0] crumb_i,
  output logic [1:0] crumb_o,
  output logic       rsvd_o
);

  assign rsvd_o  = tw_is_rsvd(crumb_i);
  assign crumb_o = rsvd_o ? TW_ZERO : crumb_i;

endmodule

// File: rtl/ternary_weight_loader.sv
// Double-buffered ternary weight loader. Crumbs fill a shadow word; a whole,
// correctly framed shadow word is copied to the active word in one commit.
module ternary_weight_loader
  import ternary_pkg::*;
#(
  parameter int N_WEIGHTS = TW_N_WEIGHTS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [1:0]             in_crumb,
  input  logic                   in_last,
  input  logic                   hold,
  input  logic                   err_clr,
  output logic [2*N_WEIGHTS-1:0] weights_out,
  output logic                   weights_valid,
  output logic                   commit_pulse,
  output logic                   rsvd_seen,
  output logic                   frame_err
);

  localparam int W  = 2 * N_WEIGHTS;
  // A single-crumb frame still needs a 1-bit counter to be legal RTL.
  localparam int CW = (N_WEIGHTS > 1) ? $clog2(N_WEIGHTS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N_WEIGHTS - 1);

  tw_state_e       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    shadow_q, shadow_d;
  logic [W-1:0]    active_q, active_d;
  logic            in_ready_q, in_ready_d;
  logic            weights_valid_q, weights_valid_d;
  logic            commit_pulse_q, commit_pulse_d;
  logic            rsvd_seen_q, rsvd_seen_d;
  logic            frame_err_q, frame_err_d;

  logic [1:0]      crumb_norm;
  logic            crumb_rsvd;
  logic            xfer;
  logic            at_last_slot;

  ternary_crumb_check u_crumb_check (
    .crumb_i (in_crumb),
    .crumb_o (crumb_norm),
    .rsvd_o  (crumb_rsvd)
  );

  assign xfer         = in_valid && in_ready_q && (state_q == FILL);
  assign at_last_slot = (cnt_q == CNT_LAST);

  // Next-state: frame assembly in FILL, commit (unless held) in FULL.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    shadow_d        = shadow_q;
    active_d        = active_q;
    weights_valid_d = weights_valid_q;
    commit_pulse_d  = 1'b0;
    rsvd_seen_d     = xfer && crumb_rsvd;
    // A new framing error below overrides a same-cycle clear.
    frame_err_d     = err_clr ? 1'b0 : frame_err_q;

    case (state_q)
      FILL: begin
        if (xfer) begin
          if (in_last && at_last_slot) begin
            shadow_d[{cnt_q, 1'b0} +: 2] = crumb_norm;
            cnt_d   = '0;
            state_d = FULL;
          end else if (in_last || at_last_slot) begin
            // Short or overlong frame: drop everything gathered so far.
            shadow_d    = '0;
            cnt_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            shadow_d[{cnt_q, 1'b0} +: 2] = crumb_norm;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      FULL: begin
        if (!hold) begin
          active_d        = shadow_q;
          shadow_d        = '0;
          commit_pulse_d  = 1'b1;
          weights_valid_d = 1'b1;
          state_d         = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    // Ready is registered from the next state so it never depends on in_valid.
    in_ready_d = (state_d == FILL);
  end

  // State and output registers; reset discards both buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= FILL;
      cnt_q           <= '0;
      shadow_q        <= '0;
      active_q        <= '0;
      in_ready_q      <= 1'b0;
      weights_valid_q <= 1'b0;
      commit_pulse_q  <= 1'b0;
      rsvd_seen_q     <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      shadow_q        <= shadow_d;
      active_q        <= active_d;
      in_ready_q      <= in_ready_d;
      weights_valid_q <= weights_valid_d;
      commit_pulse_q  <= commit_pulse_d;
      rsvd_seen_q     <= rsvd_seen_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign in_ready      = in_ready_q;
  assign weights_out   = active_q;
  assign weights_valid = weights_valid_q;
  assign commit_pulse  = commit_pulse_q;
  assign rsvd_seen     = rsvd_seen_q;
  assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_ternary_weight_loader.sv
// Directed + randomized bench for ternary_weight_loader (N_WEIGHTS = 4).
module tb_ternary_weight_loader;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] in_crumb = 2'b00;
  logic       in_last = 1'b0;
  logic       hold = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] weights_out;
  logic       weights_valid;
  logic       commit_pulse;
  logic       rsvd_seen;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: what the perceptron should currently see.
  int unsigned exp_w     = 0;
  logic        exp_valid = 1'b0;
  logic        exp_err   = 1'b0;

  ternary_weight_loader #(.N_WEIGHTS(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_crumb      (in_crumb),
    .in_last       (in_last),
    .hold          (hold),
    .err_clr       (err_clr),
    .weights_out   (weights_out),
    .weights_valid (weights_valid),
    .commit_pulse  (commit_pulse),
    .rsvd_seen     (rsvd_seen),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Word the perceptron should see: crumb k is a base-4 digit at position k,
  // reserved code counts as zero.
  function automatic int unsigned ref_word(input logic [1:0] c [4]);
    int unsigned w = 0;
    for (int k = 0; k < 4; k++)
      w += ((c[k] == 2'b10) ? 0 : int'(c[k])) * (4 ** k);
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_w"},     weights_out,   exp_w);
    chk({tag, "_valid"}, weights_valid, exp_valid);
    chk({tag, "_err"},   frame_err,     exp_err);
  endtask

  // Offer one crumb, wait (bounded) for it to be taken, check rsvd_seen.
  task automatic send(input logic [1:0] c, input logic last);
    int t = 0;
    in_valid = 1'b1;
    in_crumb = c;
    in_last  = last;
    while (!in_ready && t < 20) begin
      tick();
      t++;
    end
    if (t >= 20) chk("ready_timeout", 32'd0, 32'd1);
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("rsvd_seen", rsvd_seen, (c == 2'b10));
  endtask

  // Whole correctly framed frame with hold low; checks the T+1 commit.
  task automatic send_frame(input string tag, input logic [1:0] c [4]);
    for (int k = 0; k < 4; k++) send(c[k], k == 3);
    chk({tag, "_ready_full"}, in_ready, 1'b0);
    chk({tag, "_no_early"},   commit_pulse, 1'b0);
    tick();
    exp_w     = ref_word(c);
    exp_valid = 1'b1;
    chk({tag, "_commit"}, commit_pulse, 1'b1);
    chk({tag, "_ready"},  in_ready, 1'b1);
    chk_outs(tag);
    tick();
    chk({tag, "_pulse1"}, commit_pulse, 1'b0);
  endtask

  initial begin
    logic [1:0] f [4];
    logic [1:0] s [12];
    int commits, rdy_low, last_commit, idx;
    logic rdy;

    // Reset
    repeat (3) tick();
    chk("rst_ready", in_ready, 1'b0);
    chk("rst_commit", commit_pulse, 1'b0);
    chk("rst_rsvd", rsvd_seen, 1'b0);
    chk_outs("rst");
    reset = 1'b0;
    tick();
    chk("rst_ready_after", in_ready, 1'b1);

    // Basic load: 01,11,00,01 -> 0x4D
    f = '{2'b01, 2'b11, 2'b00, 2'b01};
    send_frame("basic", f);
    chk("basic_4d", weights_out, 8'h4D);

    // Hold: frame stays in shadow while hold is high
    hold = 1'b1;
    for (int k = 0; k < 4; k++) send(2'b01, k == 3);
    for (int k = 0; k < 10; k++) begin
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_pulse", commit_pulse, 1'b0);
      chk("hold_w", weights_out, 8'h4D);
      tick();
    end
    hold = 1'b0;
    tick();
    chk("hold_commit", commit_pulse, 1'b1);
    chk("hold_w55", weights_out, 8'h55);
    exp_w = 32'h55;
    tick();

    // Reserved codes: 10,01,10,11 -> 0xC4, rsvd_seen checked per crumb
    f = '{2'b10, 2'b01, 2'b10, 2'b11};
    send_frame("rsvd", f);
    chk("rsvd_c4", weights_out, 8'hC4);

    // Framing error: in_last on crumb 2
    send(2'b01, 1'b0);
    send(2'b01, 1'b0);
    send(2'b11, 1'b1);
    exp_err = 1'b1;
    chk("ferr_ready", in_ready, 1'b1);
    tick();
    chk("ferr_nocommit", commit_pulse, 1'b0);
    chk_outs("ferr");
    f = '{2'b11, 2'b11, 2'b11, 2'b11};
    send_frame("ferr_ff", f);
    chk("ferr_ff_val", weights_out, 8'hFF);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    exp_err = 1'b0;
    chk_outs("errclr");

    // Overlong frame with err_clr on the same edge: set wins, no commit
    for (int k = 0; k < 3; k++) send(2'b01, 1'b0);
    err_clr = 1'b1;
    send(2'b01, 1'b0);
    err_clr = 1'b0;
    exp_err = 1'b1;
    chk("long_ready", in_ready, 1'b1);
    tick();
    chk("long_nocommit", commit_pulse, 1'b0);
    chk_outs("long");

    // Reset mid-frame discards everything
    send(2'b11, 1'b0);
    send(2'b11, 1'b0);
    reset = 1'b1;
    tick();
    exp_w = 0; exp_valid = 1'b0; exp_err = 1'b0;
    chk("mrst_ready", in_ready, 1'b0);
    chk_outs("mrst");
    reset = 1'b0;
    tick();
    chk("mrst_ready_after", in_ready, 1'b1);
    f = '{2'b01, 2'b00, 2'b00, 2'b00};
    send_frame("mrst_frame", f);

    // Streaming: in_valid held high over 3 random frames
    foreach (s[i]) s[i] = 2'($urandom_range(0, 3));
    idx = 0; commits = 0; rdy_low = 0; last_commit = -1;
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      rdy = in_ready;
      if (!rdy) rdy_low++;
      in_crumb = s[idx < 12 ? idx : 11];
      in_last  = ((idx % 4) == 3);
      tick();
      chk("strm_rsvd", rsvd_seen, rdy && (in_crumb == 2'b10));
      if (rdy) idx++;
      if (commit_pulse) begin
        for (int k = 0; k < 4; k++) f[k] = s[commits*4 + k];
        exp_w = ref_word(f);
        chk("strm_w", weights_out, exp_w);
        if (last_commit >= 0) chk("strm_period", cyc - last_commit, 5);
        last_commit = cyc;
        commits++;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("strm_commits", commits, 3);
    chk("strm_rdy_low", rdy_low, 3);
    chk("strm_idx", idx, 12);
    exp_valid = 1'b1;
    chk_outs("strm_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
